// File: rtl/digit_serial_alu.sv
// Digit-serial 8-op ALU: processes a WIDTH-bit operation DIGIT bits per clock with a chained carry.
// Produces GB-style Z/N/H/C flags and uses a start/busy/done handshake toward the sequencer.
module digit_serial_alu #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_h,
    output logic             flag_c
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    // Half-carry bit position: digit 0's carry-out, or bit min(3,WIDTH-1) when only one digit exists.
    localparam int HB   = (NDIG == 1) ? ((WIDTH < 4) ? WIDTH : 4) : DIGIT;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("digit_serial_alu: WIDTH must be a multiple of DIGIT and 1 <= DIGIT <= WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r, partial, partial_next;
    logic [CW-1:0]    cnt;
    logic             carry_r, h_r;

    logic             accept, last, sub_op, logic_op, carry_init;
    logic [DIGIT-1:0] a_d, b_d, b_eff, dig_res;
    logic [DIGIT:0]   sum;
    logic             carry_out, h_now, h_use;

    assign accept = start && (state != S_RUN);
    assign last   = (cnt == CW'(NDIG - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_RUN;
            S_RUN:   if (last) state_next = S_DONE;
            S_DONE:  state_next = accept ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    always_comb begin
        case (op)
            OP_ADC:        carry_init = cin;
            OP_SUB, OP_CP: carry_init = 1'b1;
            OP_SBC:        carry_init = ~cin;
            default:       carry_init = 1'b0;
        endcase
    end

    // Subtraction runs as A + ~B + carry, so the chained carry is an inverted borrow.
    always_comb begin
        sub_op   = (op_r == OP_SUB) || (op_r == OP_SBC) || (op_r == OP_CP);
        logic_op = (op_r == OP_AND) || (op_r == OP_XOR) || (op_r == OP_OR);
        a_d      = '0;
        b_d      = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (cnt == CW'(k)) begin
                a_d = a_r[k*DIGIT +: DIGIT];
                b_d = b_r[k*DIGIT +: DIGIT];
            end
        end
        b_eff     = sub_op ? ~b_d : b_d;
        sum       = {1'b0, a_d} + {1'b0, b_eff} + {{DIGIT{1'b0}}, carry_r};
        carry_out = sum[DIGIT];
        case (op_r)
            OP_AND:  dig_res = a_d & b_d;
            OP_XOR:  dig_res = a_d ^ b_d;
            OP_OR:   dig_res = a_d | b_d;
            default: dig_res = sum[DIGIT-1:0];
        endcase
        partial_next = partial;
        for (int k = 0; k < NDIG; k++) begin
            if (cnt == CW'(k)) begin
                partial_next[k*DIGIT +: DIGIT] = dig_res;
            end
        end
    end

    generate
        if (HB < DIGIT) begin : g_h_inner
            assign h_now = sum[HB] ^ a_d[HB] ^ b_eff[HB];
        end else begin : g_h_digit
            assign h_now = sum[DIGIT];
        end
    endgenerate

    assign h_use = (cnt == '0) ? h_now : h_r;

    // Operand/partial datapath; result and flags only move on the final-digit edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r    <= '0;
            a_r     <= '0;
            b_r     <= '0;
            cnt     <= '0;
            partial <= '0;
            carry_r <= 1'b0;
            h_r     <= 1'b0;
            result  <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_h  <= 1'b0;
            flag_c  <= 1'b0;
        end else if (accept) begin
            op_r    <= op;
            a_r     <= a;
            b_r     <= b;
            cnt     <= '0;
            partial <= '0;
            carry_r <= carry_init;
            h_r     <= 1'b0;
        end else if (state == S_RUN) begin
            partial <= partial_next;
            carry_r <= carry_out;
            cnt     <= cnt + 1'b1;
            if (cnt == '0) begin
                h_r <= h_now;
            end
            if (last) begin
                if (op_r != OP_CP) begin
                    result <= partial_next;
                end
                flag_z <= (partial_next == '0);
                flag_n <= sub_op;
                flag_h <= logic_op ? (op_r == OP_AND) : (sub_op ? ~h_use : h_use);
                flag_c <= logic_op ? 1'b0 : (sub_op ? ~carry_out : carry_out);
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_alu.sv
// Directed self-checking bench for digit_serial_alu: an 8/4 instance and a 16/4 instance
// share op/operand inputs and each has its own start; expected values are hand-computed.
module tb_digit_serial_alu;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        start8, start16;
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        cin;

    logic        busy8, done8, z8, n8, h8, c8;
    logic [7:0]  result8;
    logic        busy16, done16, z16, n16, h16, c16;
    logic [15:0] result16;

    logic        sel;
    logic        dn, bz;
    logic [15:0] res;
    logic [3:0]  flags;

    int compares = 0;
    int fails    = 0;

    always #5 clk = ~clk;

    digit_serial_alu #(.WIDTH(8), .DIGIT(4)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .busy(busy8), .done(done8), .result(result8),
        .flag_z(z8), .flag_n(n8), .flag_h(h8), .flag_c(c8)
    );

    digit_serial_alu #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op), .a(a), .b(b), .cin(cin),
        .busy(busy16), .done(done16), .result(result16),
        .flag_z(z16), .flag_n(n16), .flag_h(h16), .flag_c(c16)
    );

    assign dn    = sel ? done16 : done8;
    assign bz    = sel ? busy16 : busy8;
    assign res   = sel ? result16 : {8'h00, result8};
    assign flags = sel ? {z16, n16, h16, c16} : {z8, n8, h8, c8};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one request and returns at the falling edge of the first cycle after acceptance.
    task automatic applyStimulus(input logic wide, input logic [2:0] o,
                                 input logic [15:0] av, input logic [15:0] bv, input logic ci);
        @(negedge clk);
        sel = wide;
        op  = o;
        a   = av;
        b   = bv;
        cin = ci;
        if (wide) start16 = 1'b1;
        else      start8  = 1'b1;
        @(negedge clk);
        start8  = 1'b0;
        start16 = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic wide, input logic [2:0] o,
                         input logic [15:0] av, input logic [15:0] bv, input logic ci,
                         input int expLat);
        int n;
        int busyCycles;
        applyStimulus(wide, o, av, bv, ci);
        n = 1;
        busyCycles = 0;
        while (!dn && n < 20) begin
            if (bz) busyCycles++;
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " latency"}, n, expLat);
        checkOutput({tag, " busy cycles"}, busyCycles, expLat - 1);
    endtask

    initial begin
        int n;
        int doneSeen;

        reset   = 1'b1;
        start8  = 1'b0;
        start16 = 1'b0;
        sel     = 1'b0;
        op      = OP_ADD;
        a       = '0;
        b       = '0;
        cin     = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy8", busy8, 0);
        checkOutput("reset done8", done8, 0);
        checkOutput("reset result8", result8, 0);
        checkOutput("reset flags8", {z8, n8, h8, c8}, 4'b0000);
        checkOutput("reset result16", result16, 0);
        reset = 1'b0;

        runOp("or", 1'b0, OP_OR, 16'h5A, 16'h81, 1'b0, 3);
        checkOutput("or result", res, 16'hDB);
        checkOutput("or flags", flags, 4'b0000);

        runOp("add 0f+01", 1'b0, OP_ADD, 16'h0F, 16'h01, 1'b0, 3);
        checkOutput("add 0f+01 result", res, 16'h10);
        checkOutput("add 0f+01 flags", flags, 4'b0010);

        runOp("add ff+01", 1'b0, OP_ADD, 16'hFF, 16'h01, 1'b0, 3);
        checkOutput("add ff+01 result", res, 16'h00);
        checkOutput("add ff+01 flags", flags, 4'b1011);

        runOp("sub 10-01", 1'b0, OP_SUB, 16'h10, 16'h01, 1'b0, 3);
        checkOutput("sub 10-01 result", res, 16'h0F);
        checkOutput("sub 10-01 flags", flags, 4'b0110);

        runOp("cp 10,20", 1'b0, OP_CP, 16'h10, 16'h20, 1'b0, 3);
        checkOutput("cp result held", res, 16'h0F);
        checkOutput("cp flags", flags, 4'b0101);

        runOp("and f0&0f", 1'b0, OP_AND, 16'hF0, 16'h0F, 1'b0, 3);
        checkOutput("and result", res, 16'h00);
        checkOutput("and flags", flags, 4'b1010);

        // Back-to-back: start stays high through the done cycle of the first op.
        @(negedge clk);
        sel    = 1'b0;
        op     = OP_ADD;
        a      = 16'h22;
        b      = 16'h11;
        start8 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dn && n < 20);
        checkOutput("b2b first latency", n, 3);
        checkOutput("b2b first result", res, 16'h33);
        op = OP_XOR;
        a  = 16'h3C;
        b  = 16'hFF;
        n = 0;
        do begin
            @(negedge clk);
            start8 = 1'b0;
            n++;
        end while (!dn && n < 20);
        checkOutput("b2b second latency", n, 3);
        checkOutput("b2b second result", res, 16'hC3);
        checkOutput("b2b second flags", flags, 4'b0000);

        // A start pulse while busy must be dropped without queueing.
        applyStimulus(1'b0, OP_ADD, 16'h01, 16'h02, 1'b0);
        checkOutput("busy during op", bz, 1);
        a      = 16'h40;
        b      = 16'h40;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        checkOutput("ignored start done", dn, 1);
        checkOutput("ignored start result", res, 16'h03);
        @(negedge clk);
        checkOutput("no queued op busy", bz, 0);
        checkOutput("no queued op done", dn, 0);

        // Asynchronous reset in the middle of an operation.
        applyStimulus(1'b0, OP_SUB, 16'h50, 16'h20, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("midop reset busy", bz, 0);
        checkOutput("midop reset done", dn, 0);
        checkOutput("midop reset result", res, 16'h00);
        checkOutput("midop reset flags", flags, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        doneSeen = 0;
        repeat (6) begin
            @(negedge clk);
            if (dn) doneSeen++;
        end
        checkOutput("midop reset no done", doneSeen, 0);
        checkOutput("midop reset result stays", res, 16'h00);

        runOp("adc16", 1'b1, OP_ADC, 16'hFFFF, 16'h0000, 1'b1, 5);
        checkOutput("adc16 result", res, 16'h0000);
        checkOutput("adc16 flags", flags, 4'b1011);

        runOp("sbc16", 1'b1, OP_SBC, 16'h0000, 16'h0000, 1'b1, 5);
        checkOutput("sbc16 result", res, 16'hFFFF);
        checkOutput("sbc16 flags", flags, 4'b0111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
